// File: rtl/clahe_pkg.sv
// Shared constants and types for the CLAHE histogram path (stat stage and RAM bank).
// The bank is indexed as {tile, bin}; counts are CNT_W wide and saturate.
package clahe_pkg;

    localparam int TILE_NUM   = 64;
    localparam int BINS       = 256;
    localparam int CNT_W      = 16;
    localparam int TILE_IDX_W = 6;
    localparam int BIN_W      = 8;

    typedef logic [TILE_IDX_W-1:0] tile_idx_t;
    typedef logic [BIN_W-1:0]      bin_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    typedef struct packed {
        tile_idx_t tile;
        bin_t      bin;
    } hist_key_t;

    typedef struct packed {
        logic      vld;
        hist_key_t key;
    } addr_stage_t;

    typedef struct packed {
        logic      vld;
        hist_key_t key;
        cnt_t      cnt;
    } cnt_stage_t;

    localparam hist_key_t   HIST_KEY_ZERO   = '{tile: 6'd0, bin: 8'd0};
    localparam addr_stage_t ADDR_STAGE_IDLE = '{vld: 1'b0, key: HIST_KEY_ZERO};
    localparam cnt_stage_t  CNT_STAGE_IDLE  = '{vld: 1'b0, key: HIST_KEY_ZERO, cnt: 16'd0};

    // Bin increment that sticks at the top of the counter range
    function automatic cnt_t sat_inc(input cnt_t val);
        cnt_t res;
        if (val == {CNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + 16'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clahe_tile_locator.sv
// Raster position tracker: x/y counters plus sub-tile counters that step the
// tile column/row without any division, yielding the tile index of the current pixel.
module clahe_tile_locator
    import clahe_pkg::*;
#(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 720,
    parameter int TILE_COLS = 8,
    parameter int TILE_ROWS = 8
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  frame_active,
    input  logic                  in_href,
    output logic [TILE_IDX_W-1:0] tile_idx,
    output logic                  pix_valid
);

    localparam int TILE_W = IMG_W / TILE_COLS;
    localparam int TILE_H = IMG_H / TILE_ROWS;
    localparam int X_W    = $clog2(IMG_W + 1);
    localparam int Y_W    = $clog2(IMG_H + 1);

    logic            href_d_r;
    logic [X_W-1:0]  x_cnt_r, x_cnt_nxt, sub_x_r, sub_x_nxt;
    logic [Y_W-1:0]  y_cnt_r, y_cnt_nxt, sub_y_r, sub_y_nxt;
    tile_idx_t       col_r, col_nxt, row_r, row_nxt;
    logic            href_fall_s, adv_x_s, adv_y_s;

    // Position strobes and pixel qualification; x saturates at IMG_W, y at IMG_H
    always_comb begin
        href_fall_s = href_d_r & ~in_href;
        adv_x_s     = in_href & frame_active & (x_cnt_r < X_W'(IMG_W));
        adv_y_s     = href_fall_s & frame_active & (y_cnt_r < Y_W'(IMG_H));
        pix_valid   = adv_x_s & (y_cnt_r < Y_W'(IMG_H));
        tile_idx    = row_r * TILE_IDX_W'(TILE_COLS) + col_r;
    end

    // Next-state for the horizontal and vertical counter chains
    always_comb begin
        x_cnt_nxt = x_cnt_r;
        sub_x_nxt = sub_x_r;
        col_nxt   = col_r;
        y_cnt_nxt = y_cnt_r;
        sub_y_nxt = sub_y_r;
        row_nxt   = row_r;
        if (frame_start) begin
            x_cnt_nxt = {X_W{1'b0}};
            sub_x_nxt = {X_W{1'b0}};
            col_nxt   = {TILE_IDX_W{1'b0}};
            y_cnt_nxt = {Y_W{1'b0}};
            sub_y_nxt = {Y_W{1'b0}};
            row_nxt   = {TILE_IDX_W{1'b0}};
        end else begin
            if (href_fall_s) begin
                x_cnt_nxt = {X_W{1'b0}};
                sub_x_nxt = {X_W{1'b0}};
                col_nxt   = {TILE_IDX_W{1'b0}};
            end else if (adv_x_s) begin
                x_cnt_nxt = x_cnt_r + X_W'(1);
                if (sub_x_r == X_W'(TILE_W - 1)) begin
                    sub_x_nxt = {X_W{1'b0}};
                    if (col_r == TILE_IDX_W'(TILE_COLS - 1)) begin
                        col_nxt = {TILE_IDX_W{1'b0}};
                    end else begin
                        col_nxt = col_r + TILE_IDX_W'(1);
                    end
                end else begin
                    sub_x_nxt = sub_x_r + X_W'(1);
                end
            end else begin
                x_cnt_nxt = x_cnt_r;
            end
            if (adv_y_s) begin
                y_cnt_nxt = y_cnt_r + Y_W'(1);
                if (sub_y_r == Y_W'(TILE_H - 1)) begin
                    sub_y_nxt = {Y_W{1'b0}};
                    if (row_r == TILE_IDX_W'(TILE_ROWS - 1)) begin
                        row_nxt = {TILE_IDX_W{1'b0}};
                    end else begin
                        row_nxt = row_r + TILE_IDX_W'(1);
                    end
                end else begin
                    sub_y_nxt = sub_y_r + Y_W'(1);
                end
            end else begin
                y_cnt_nxt = y_cnt_r;
            end
        end
    end

    // Counter registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_d_r <= 1'b0;
            x_cnt_r  <= {X_W{1'b0}};
            sub_x_r  <= {X_W{1'b0}};
            col_r    <= {TILE_IDX_W{1'b0}};
            y_cnt_r  <= {Y_W{1'b0}};
            sub_y_r  <= {Y_W{1'b0}};
            row_r    <= {TILE_IDX_W{1'b0}};
        end else begin
            href_d_r <= in_href;
            x_cnt_r  <= x_cnt_nxt;
            sub_x_r  <= sub_x_nxt;
            col_r    <= col_nxt;
            y_cnt_r  <= y_cnt_nxt;
            sub_y_r  <= sub_y_nxt;
            row_r    <= row_nxt;
        end
    end

endmodule

// File: rtl/clahe_hist_stat.sv
// Per-pixel tile histogram accumulator: 1 pixel/clock read-modify-write of the
// tile's bin in the ping-pong bank, with S2/S3 forwarding and frame-done signalling.
module clahe_hist_stat
    import clahe_pkg::*;
#(
    parameter int IMG_W     = 1280,
    parameter int IMG_H     = 720,
    parameter int TILE_COLS = 8,
    parameter int TILE_ROWS = 8
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  in_vsync,
    input  logic                  in_href,
    input  logic [BIN_W-1:0]      in_y,
    input  logic                  clear_done,
    output logic [TILE_IDX_W-1:0] hist_rd_tile_idx,
    output logic [BIN_W-1:0]      hist_rd_addr,
    input  logic [CNT_W-1:0]      hist_rd_data,
    output logic [TILE_IDX_W-1:0] hist_wr_tile_idx,
    output logic [BIN_W-1:0]      hist_wr_addr,
    output logic [CNT_W-1:0]      hist_wr_data,
    output logic                  hist_wr_en,
    output logic                  hist_frame_done,
    output logic                  err_clear_overlap
);

    logic        vsync_d_r, frame_active_r, err_r, done_pend_r, frame_done_r;
    addr_stage_t s0_r, s1_r, s0_nxt;
    cnt_stage_t  s2_r, s3_r, s2_nxt;
    logic        vsync_rise_s, pix_valid_s, accept_s;
    tile_idx_t   loc_tile_s;
    logic        fwd2_s, fwd3_s, pend_s, done_now_s;
    cnt_t        base_s;

    clahe_tile_locator #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .TILE_COLS (TILE_COLS),
        .TILE_ROWS (TILE_ROWS)
    ) u_locator (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .frame_start  (vsync_rise_s),
        .frame_active (frame_active_r),
        .in_href      (in_href),
        .tile_idx     (loc_tile_s),
        .pix_valid    (pix_valid_s)
    );

    // Acceptance, S0 load, bin forwarding and frame-done qualification
    always_comb begin
        vsync_rise_s = in_vsync & ~vsync_d_r;
        accept_s     = pix_valid_s & clear_done;

        s0_nxt     = s0_r;
        s0_nxt.vld = accept_s;
        if (accept_s) begin
            s0_nxt.key = '{tile: loc_tile_s, bin: in_y};
        end else begin
            s0_nxt.key = s0_r.key;
        end

        // The RAM read for S1 was issued before S2/S3 landed, so their counts win
        fwd2_s = s2_r.vld & (s2_r.key == s1_r.key);
        fwd3_s = s3_r.vld & (s3_r.key == s1_r.key);
        if (fwd2_s) begin
            base_s = s2_r.cnt;
        end else if (fwd3_s) begin
            base_s = s3_r.cnt;
        end else begin
            base_s = hist_rd_data;
        end
        s2_nxt = '{vld: s1_r.vld, key: s1_r.key, cnt: sat_inc(base_s)};

        // Done fires in the first cycle where S0..S2 will all be empty
        pend_s     = done_pend_r | (vsync_rise_s & frame_active_r);
        done_now_s = pend_s & ~accept_s & ~s0_r.vld & ~s1_r.vld;
    end

    // RMW pipeline stages S0..S3
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s0_r <= ADDR_STAGE_IDLE;
            s1_r <= ADDR_STAGE_IDLE;
            s2_r <= CNT_STAGE_IDLE;
            s3_r <= CNT_STAGE_IDLE;
        end else begin
            s0_r <= s0_nxt;
            s1_r <= s0_r;
            s2_r <= s2_nxt;
            s3_r <= s2_r;
        end
    end

    // Frame control, sticky clear-overlap flag and frame-done pulse
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r      <= 1'b0;
            frame_active_r <= 1'b0;
            err_r          <= 1'b0;
            done_pend_r    <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            vsync_d_r    <= in_vsync;
            done_pend_r  <= pend_s & ~done_now_s;
            frame_done_r <= done_now_s;
            if (vsync_rise_s) begin
                frame_active_r <= 1'b1;
                err_r          <= 1'b0;
            end else if (pix_valid_s && !clear_done) begin
                frame_active_r <= frame_active_r;
                err_r          <= 1'b1;
            end else begin
                frame_active_r <= frame_active_r;
                err_r          <= err_r;
            end
        end
    end

    assign hist_rd_tile_idx  = s0_r.key.tile;
    assign hist_rd_addr      = s0_r.key.bin;
    assign hist_wr_tile_idx  = s2_r.key.tile;
    assign hist_wr_addr      = s2_r.key.bin;
    assign hist_wr_data      = s2_r.cnt;
    assign hist_wr_en        = s2_r.vld;
    assign hist_frame_done   = frame_done_r;
    assign err_clear_overlap = err_r;

endmodule

// File: tb/tb_clahe_hist_stat.sv
// Directed bench for clahe_hist_stat on a reduced 128x40 frame (16x5 tiles) with a
// behavioural bank RAM and an expected-write queue drained on every hist_wr_en.
module tb_clahe_hist_stat;

    localparam int IMG_W     = 128;
    localparam int IMG_H     = 40;
    localparam int TILE_COLS = 8;
    localparam int TILE_ROWS = 8;
    localparam int TILE_W    = IMG_W / TILE_COLS;
    localparam int TILE_H    = IMG_H / TILE_ROWS;
    localparam int GAP       = 3;

    logic        pclk = 1'b0;
    logic        rst_n, in_vsync, in_href, clear_done;
    logic [7:0]  in_y;
    logic [5:0]  hist_rd_tile_idx, hist_wr_tile_idx;
    logic [7:0]  hist_rd_addr, hist_wr_addr;
    logic [15:0] hist_rd_data, hist_wr_data;
    logic        hist_wr_en, hist_frame_done, err_clear_overlap;

    always #5 pclk = ~pclk;

    clahe_hist_stat #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .TILE_COLS (TILE_COLS),
        .TILE_ROWS (TILE_ROWS)
    ) dut (
        .pclk              (pclk),
        .rst_n             (rst_n),
        .in_vsync          (in_vsync),
        .in_href           (in_href),
        .in_y              (in_y),
        .clear_done        (clear_done),
        .hist_rd_tile_idx  (hist_rd_tile_idx),
        .hist_rd_addr      (hist_rd_addr),
        .hist_rd_data      (hist_rd_data),
        .hist_wr_tile_idx  (hist_wr_tile_idx),
        .hist_wr_addr      (hist_wr_addr),
        .hist_wr_data      (hist_wr_data),
        .hist_wr_en        (hist_wr_en),
        .hist_frame_done   (hist_frame_done),
        .err_clear_overlap (err_clear_overlap)
    );

    // Bank RAM: one-cycle read latency, preload/clear requests from the stimulus
    logic [15:0] mem [0:16383];
    logic        ram_clr, pre_en;
    logic [13:0] pre_idx;
    logic [15:0] pre_val;

    always @(posedge pclk) begin
        hist_rd_data <= mem[{hist_rd_tile_idx, hist_rd_addr}];
        if (ram_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'h0000;
        end else begin
            if (pre_en) mem[pre_idx] <= pre_val;
            if (hist_wr_en) mem[{hist_wr_tile_idx, hist_wr_addr}] <= hist_wr_data;
        end
    end

    logic [29:0] exp_q[$];
    logic [15:0] exp_cnt [0:16383];
    logic [7:0]  line_y  [0:255];
    logic        line_cd [0:255];
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int wr_cnt = 0, done_cnt = 0;
    int cur_row;
    bit frame_on;
    int w0, d0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Write monitor: every write must match the oldest expected {tile, bin, count}
    initial begin
        forever begin
            @(negedge pclk);
            if (hist_frame_done === 1'b1) done_cnt++;
            if (hist_wr_en === 1'b1) begin
                wr_cnt++;
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("wr_tile_addr_data", {2'b00, hist_wr_tile_idx, hist_wr_addr, hist_wr_data},
                          {2'b00, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_pix(input int x, input logic [7:0] yv, input logic cd);
        int idx;
        logic [5:0] t;
        in_href = 1'b1;
        in_y = yv;
        clear_done = cd;
        if (frame_on && x < IMG_W && cur_row < IMG_H && cd) begin
            t = 6'((cur_row / TILE_H) * TILE_COLS + x / TILE_W);
            idx = int'(t) * 256 + int'(yv);
            if (exp_cnt[idx] != 16'hFFFF) exp_cnt[idx] = exp_cnt[idx] + 16'd1;
            exp_q.push_back({t, yv, exp_cnt[idx]});
        end
        step();
    endtask

    task automatic end_line(input int gap);
        in_href = 1'b0;
        clear_done = 1'b1;
        if (frame_on) cur_row++;
        repeat (gap) step();
    endtask

    task automatic send_line(input int n, input int gap);
        for (int i = 0; i < n; i++) drive_pix(i, line_y[i], line_cd[i]);
        end_line(gap);
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1;
        step();
        in_vsync = 1'b0;
        frame_on = 1'b1;
        cur_row = 0;
        step();
    endtask

    task automatic ram_clear();
        ram_clr = 1'b1;
        step();
        ram_clr = 1'b0;
        for (int i = 0; i < 16384; i++) exp_cnt[i] = 16'h0000;
    endtask

    task automatic ram_preset(input int idx, input logic [15:0] v);
        pre_en = 1'b1;
        pre_idx = 14'(idx);
        pre_val = v;
        step();
        pre_en = 1'b0;
        exp_cnt[idx] = v;
    endtask

    initial begin
        rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_y = 8'h00; clear_done = 1'b1;
        ram_clr = 1'b0; pre_en = 1'b0; pre_idx = 14'd0; pre_val = 16'd0;
        frame_on = 1'b0; cur_row = 0;
        for (int i = 0; i < 256; i++) begin
            line_y[i] = 8'h00;
            line_cd[i] = 1'b1;
        end
        repeat (3) step();
        check("rst_wr_en", 32'(hist_wr_en), 32'd0);
        check("rst_frame_done", 32'(hist_frame_done), 32'd0);
        check("rst_err", 32'(err_clear_overlap), 32'd0);
        check("rst_rd_addr", 32'(hist_rd_addr), 32'd0);
        check("rst_wr_data", 32'(hist_wr_data), 32'd0);
        rst_n = 1'b1;
        ram_clear();
        step();

        // Pixels before the first vsync are ignored
        for (int i = 0; i < 8; i++) line_y[i] = 8'(i + 1);
        send_line(8, GAP + 2);
        check("pre_vsync_writes", 32'(wr_cnt), 32'd0);
        vsync_pulse();
        repeat (4) step();
        check("first_vsync_no_done", 32'(done_cnt), 32'd0);

        // Single pixel at (0,0), bin preloaded with 5
        ram_preset(8'h40, 16'd5);
        drive_pix(0, 8'h40, 1'b1);
        check("lat_rd_addr", 32'(hist_rd_addr), 32'h40);
        end_line(0);
        check("lat_c1_wr_en", 32'(hist_wr_en), 32'd0);
        step();
        check("lat_c2_wr_en", 32'(hist_wr_en), 32'd0);
        step();
        check("lat_c3_wr_en", 32'(hist_wr_en), 32'd1);
        check("lat_c3_wr_data", 32'(hist_wr_data), 32'd6);
        step();
        check("lat_c4_wr_en", 32'(hist_wr_en), 32'd0);
        repeat (GAP) step();

        // Ten back-to-back hits on one bin
        for (int i = 0; i < 10; i++) line_y[i] = 8'h80;
        send_line(10, GAP + 2);
        check("fwd1_final", 32'(mem[16'h0080]), 32'd10);

        // Alternating bins 3,7
        for (int i = 0; i < 6; i++) line_y[i] = (i % 2 == 0) ? 8'd3 : 8'd7;
        send_line(6, GAP + 2);
        check("fwd2_bin3", 32'(mem[3]), 32'd3);
        check("fwd2_bin7", 32'(mem[7]), 32'd3);

        // Horizontal tile boundary at x = TILE_W
        for (int i = 0; i < 17; i++) line_y[i] = 8'hA0;
        send_line(17, GAP + 2);
        check("tile0_edge", 32'(mem[8'hA0]), 32'd16);
        check("tile1_edge", 32'(mem[256 + 8'hA0]), 32'd1);

        // Rows 4..38 one pixel each; row TILE_H starts tile 8
        line_y[0] = 8'hC0;
        for (int r = 4; r < IMG_H - 1; r++) send_line(1, GAP);
        repeat (2) step();
        check("row4_tile0", 32'(mem[8'hC0]), 32'd1);
        check("tile8_rows", 32'(mem[8 * 256 + 8'hC0]), 32'd5);

        // Last row with two extra pixels past IMG_W
        for (int i = 0; i < IMG_W + 2; i++) line_y[i] = 8'hE0;
        send_line(IMG_W + 2, GAP + 2);
        check("tile63_last", 32'(mem[63 * 256 + 8'hE0]), 32'd16);
        w0 = wr_cnt;
        send_line(4, GAP + 2);
        check("row_past_img_h", 32'(wr_cnt - w0), 32'd0);
        vsync_pulse();
        repeat (4) step();
        check("done_after_frame1", 32'(done_cnt), 32'd1);

        // Full frame of random pixels, vsync right after the last one
        ram_clear();
        w0 = wr_cnt;
        for (int r = 0; r < IMG_H; r++) begin
            for (int i = 0; i < IMG_W; i++) line_y[i] = 8'($urandom_range(0, 255));
            send_line(IMG_W, (r == IMG_H - 1) ? 0 : GAP);
        end
        in_vsync = 1'b1;
        step();
        check("done_c1", 32'(hist_frame_done), 32'd0);
        step();
        check("done_c2", 32'(hist_frame_done), 32'd0);
        step();
        check("done_c3", 32'(hist_frame_done), 32'd1);
        step();
        check("done_c4", 32'(hist_frame_done), 32'd0);
        in_vsync = 1'b0;
        frame_on = 1'b1;
        cur_row = 0;
        check("frame_writes", 32'(wr_cnt - w0), 32'(IMG_W * IMG_H));
        check("done_count2", 32'(done_cnt), 32'd2);

        // clear_done low for five pixels
        w0 = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            line_y[i] = 8'h55;
            line_cd[i] = (i >= 2 && i <= 6) ? 1'b0 : 1'b1;
        end
        send_line(10, GAP + 2);
        for (int i = 0; i < 10; i++) line_cd[i] = 1'b1;
        check("cd_writes", 32'(wr_cnt - w0), 32'd5);
        check("err_set", 32'(err_clear_overlap), 32'd1);
        send_line(3, GAP + 2);
        check("err_sticky", 32'(err_clear_overlap), 32'd1);
        vsync_pulse();
        check("err_cleared", 32'(err_clear_overlap), 32'd0);
        repeat (3) step();
        check("done_count3", 32'(done_cnt), 32'd3);

        // Reset with two pixels in flight
        w0 = wr_cnt;
        d0 = done_cnt;
        in_href = 1'b1;
        in_y = 8'h11;
        clear_done = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(hist_wr_en), 32'd0);
        check("mid_rst_rd_addr", 32'(hist_rd_addr), 32'd0);
        check("mid_rst_done", 32'(hist_frame_done), 32'd0);
        in_href = 1'b0;
        frame_on = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("mid_rst_no_write", 32'(wr_cnt - w0), 32'd0);
        for (int i = 0; i < 5; i++) line_y[i] = 8'h22;
        send_line(5, GAP + 2);
        check("post_rst_inactive", 32'(wr_cnt - w0), 32'd0);
        vsync_pulse();
        repeat (4) step();
        check("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
        line_y[0] = 8'h11;
        send_line(1, GAP + 2);
        check("post_rst_recover", 32'(wr_cnt - w0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clahe_hist_stat.md
Name: clahe_hist_stat

Overview:
- Per-pixel histogram accumulator feeding the 64-tile ping-pong histogram/CDF RAM bank.
- Tracks raster position and derives the tile index (8x8 grid) for each incoming Y pixel.
- Performs a pipelined read-modify-write (+1) on that tile's bin through the bank's hist read/write ports, at 1 pixel/clock with hazard forwarding.
- Signals frame completion to the CDF stage once all increments have been written.

Parameters:
- IMG_W, 1280, active pixels per line
- IMG_H, 720, active lines per frame
- TILE_COLS, 8, tiles horizontally
- TILE_ROWS, 8, tiles vertically (TILE_COLS*TILE_ROWS = 64; IMG_W and IMG_H divide exactly)
- CNT_W, 16, bin counter width

Ports:
- pclk  in  1  pixel clock, sole clock
- rst_n  in  1  asynchronous active-low reset
- in_vsync  in  1  frame sync, active high; rising edge = frame boundary
- in_href  in  1  line valid; pixel accepted every cycle it is high
- in_y  in  8  luminance
- clear_done  in  1  bank clear finished (from RAM bank)
- hist_rd_tile_idx  out  6  tile of bin being read
- hist_rd_addr  out  8  bin being read
- hist_rd_data  in  16  bin value, valid one cycle after address
- hist_wr_tile_idx  out  6  tile of bin being written
- hist_wr_addr  out  8  bin written
- hist_wr_data  out  16  incremented count
- hist_wr_en  out  1  write strobe
- hist_frame_done  out  1  one-cycle pulse: frame histogram complete
- err_clear_overlap  out  1  sticky: pixel dropped because clear_done was low

Behaviour:
- Reset values: all outputs 0. Counters are 0. Pipeline valid bits are 0. Internal frame_active is 0.
- Position: x_cnt increments per accepted pixel and resets on the falling edge of in_href. y_cnt increments on the href falling edge.
  - Sub-tile counters and col/row indices wrap at TILE_W = IMG_W/TILE_COLS and TILE_H = IMG_H/TILE_ROWS.
  - No divider. tile_idx = row*TILE_COLS + col.
- Frame start: on the in_vsync rising edge, all position counters and err_clear_overlap clear, and frame_active is set.
- Pixels with x_cnt >= IMG_W or y_cnt >= IMG_H are ignored. Pixels arriving before the first vsync are ignored.
- Pixel acceptance requires in_href & frame_active & clear_done. If clear_done is low, the pixel is dropped and err_clear_overlap is set.
- Pipeline (latency 3 cycles from in_y to hist_wr_en):
  - S0, edge after input: register {tile, bin, v0}. Drive hist_rd_tile_idx and hist_rd_addr from S0.
  - S1: register {tile, bin, v1}. hist_rd_data is valid this cycle. Compute base = fwd ? fwd_val : hist_rd_data, then next = base + 1, saturating at 2^CNT_W-1.
  - S2: register {tile, bin, next, v2}. Drive the write port from S2; hist_wr_en = v2.
  - S3: copy of S2 as last-written, used only for forwarding.
- Forwarding (the RAM's read-during-write result is not relied upon):
  - If S2 is valid with the same {tile, bin} as S1, fwd_val = S2.count.
  - Else if S3 is valid with the same {tile, bin}, fwd_val = S3.count.
  - S2 has priority over S3.
- Frame end: on a vsync rising edge while frame_active, hist_frame_done pulses on the first cycle when S0..S2 are all invalid.
  - With a continuous stream, this is 3 cycles after the last accepted pixel.
  - The new frame begins counting immediately. Its pixels cannot arrive before the next href, so no overlap check is needed.
- Reset mid-frame: pipeline is flushed without writing, and no hist_frame_done is issued.

Decomposition:
- Shared package clahe_pkg holds TILE_NUM=64, BINS=256, CNT_W and the tile-index width 6. The RAM bank uses the same constants.
- Optional sub-module clahe_tile_locator holds the x/y, sub-tile and col/row counters and outputs {tile_idx, pix_valid}. The RMW pipeline and frame control stay in the top.

Test Plan:
- One pixel y=0x40 at (0,0), RAM bin=5 -> write tile 0, addr 0x40, data 6, hist_wr_en exactly 3 cycles after input.
- 10 back-to-back pixels y=0x80 in tile 0, bin initially 0 -> 10 writes with data 1..10 (distance-1 forwarding).
- Pattern A,B,A,B,A,B (y=3,7), initial 0 -> writes for bin 3 read 1,2,3 and bin 7 read 1,2,3 (distance-2 forwarding).
- Line pixels at x=159 and x=160 -> tile 0 then tile 1; first pixel of line 90 -> tile 8; last pixel (1279,719) -> tile 63.
- Full frame then vsync rise -> hist_frame_done single pulse 3 cycles after last pixel; total write count = 921600.
- clear_done held low for 5 pixels -> no writes for them, err_clear_overlap=1 until next vsync rise. Separately, assert rst_n low mid-line -> outputs 0, no write, no frame_done.
